// File: rtl/tc77_pkg.sv
// Shared definitions for the TC77 sensor responder: FSM encoding, config
// command words, frame lengths and the temperature LSB weight.
package tc77_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_HOLD  = 2'd3
   } tc77_state_e;

   localparam logic [15:0] TC77_CFG_SHUTDOWN   = 16'hFFFF;
   localparam logic [15:0] TC77_CFG_CONTINUOUS = 16'h0000;

   localparam int READ_BITS  = 16;
   localparam int FRAME_BITS = 32;
   localparam int TEMP_W     = 13;

   // One temperature LSB in micro-degrees Celsius (0.0625 C).
   localparam int TC77_LSB_UC = 62500;

   // Serial output word; the two trailing bits are never driven on the pin.
   function automatic logic [15:0] tc77_word(input logic [TEMP_W-1:0] temp,
                                             input logic              done);
      return {temp, done, 2'b00};
   endfunction

endpackage

// File: rtl/tc77_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input with single-cycle
// rise/fall strobes generated on the synchronised copy.
module tc77_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic MCLK,
   input  logic RESET,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Reset to low so that an input already low at reset release yields no fall.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/tc77_responder.sv
// Device-side TC77 model: periodic conversion of TEMP_IN, 16-bit read frame
// over SIO and optional 16-bit config write selecting shutdown/continuous mode.
module tc77_responder
   import tc77_pkg::*;
#(
   parameter int CONV_CYCLES = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              MCLK,
   input  logic              RESET,
   input  logic [TEMP_W-1:0] TEMP_IN,
   input  logic              nCS,
   input  logic              SCLK,
   input  logic              SIO_IN,
   output logic              SIO_OUT,
   output logic              SIO_OE,
   output logic              SHUTDOWN,
   output logic              CONV_DONE
);

   localparam int              CNT_W     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

   logic              ncs_rise, ncs_fall, sclk_rise, sclk_fall;
   tc77_state_e       state_q, state_d;
   logic [15:0]       sreg_q;
   logic [5:0]        bit_cnt_q;
   logic [15:0]       cfg_sr_q;
   logic [15:0]       cfg_q;
   logic [TEMP_W-1:0] temp_q;
   logic              conv_done_q;
   logic              conv_pend_q;
   logic [CNT_W-1:0]  conv_cnt_q;
   logic              conv_end;
   logic              shutdown;
   logic              commit, commit_shdn, commit_cont;

   tc77_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
      .MCLK  (MCLK),
      .RESET (RESET),
      .d     (nCS),
      .rise  (ncs_rise),
      .fall  (ncs_fall)
   );

   tc77_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
      .MCLK  (MCLK),
      .RESET (RESET),
      .d     (SCLK),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   assign shutdown    = (cfg_q == TC77_CFG_SHUTDOWN);
   // Only a frame that reached HOLD delivered all 32 bits.
   assign commit      = ncs_rise && (state_q == ST_HOLD);
   assign commit_shdn = commit && (cfg_sr_q == TC77_CFG_SHUTDOWN);
   assign commit_cont = commit && (cfg_sr_q == TC77_CFG_CONTINUOUS);
   assign conv_end    = (conv_cnt_q == CONV_LAST);

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ncs_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (ncs_fall) state_d = ST_READ;
            ST_READ:  if (sclk_fall && bit_cnt_q == 6'(READ_BITS - 1)) state_d = ST_WRITE;
            ST_WRITE: if (sclk_rise && bit_cnt_q == 6'(FRAME_BITS - 1)) state_d = ST_HOLD;
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      SIO_OE  = 1'b0;
      SIO_OUT = 1'b0;
      if (state_q == ST_READ && bit_cnt_q < 6'(READ_BITS - 2)) begin
         SIO_OE  = 1'b1;
         SIO_OUT = sreg_q[15];
      end
   end

   // SCLK edges are discarded when nCS rises in the same cycle.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         cfg_sr_q  <= '0;
         cfg_q     <= TC77_CFG_CONTINUOUS;
      end else begin
         if (!ncs_rise) begin
            case (state_q)
               ST_IDLE: if (ncs_fall) begin
                  sreg_q    <= tc77_word(temp_q, conv_done_q);
                  bit_cnt_q <= '0;
               end
               ST_READ: if (sclk_fall) begin
                  sreg_q    <= {sreg_q[14:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 6'd1;
               end
               // SIO_IN is still held by the master a few MCLK after its SCLK rise.
               ST_WRITE: if (sclk_rise) begin
                  cfg_sr_q  <= {cfg_sr_q[14:0], SIO_IN};
                  bit_cnt_q <= bit_cnt_q + 6'd1;
               end
               default: ;
            endcase
         end
         if (commit_shdn)      cfg_q <= TC77_CFG_SHUTDOWN;
         else if (commit_cont) cfg_q <= TC77_CFG_CONTINUOUS;
      end
   end

   // A conversion ending during READ is deferred until READ exits.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         conv_cnt_q  <= '0;
         temp_q      <= '0;
         conv_done_q <= 1'b0;
         conv_pend_q <= 1'b0;
      end else if (commit_cont) begin
         conv_cnt_q  <= '0;
         conv_done_q <= 1'b0;
         conv_pend_q <= 1'b0;
      end else if (shutdown) begin
         conv_cnt_q <= '0;
      end else begin
         conv_cnt_q <= conv_end ? '0 : conv_cnt_q + CNT_W'(1);
         if (conv_end || conv_pend_q) begin
            if (state_q == ST_READ) begin
               conv_pend_q <= 1'b1;
            end else begin
               temp_q      <= TEMP_IN;
               conv_done_q <= 1'b1;
               conv_pend_q <= 1'b0;
            end
         end
      end
   end

   assign SHUTDOWN  = shutdown;
   assign CONV_DONE = conv_done_q;

endmodule

// File: tb/tb_tc77_responder.sv
// Bench for tc77_responder: a bit-banged master reads/writes frames and a
// scoreboard compares each captured word with the value queued at nCS fall.
module tb_tc77_responder;

   localparam int CONV = 400;
   localparam int HALF = 5;

   logic        MCLK = 1'b0;
   logic        RESET;
   logic [12:0] TEMP_IN;
   logic        nCS, SCLK, SIO_IN;
   logic        SIO_OUT, SIO_OE, SHUTDOWN, CONV_DONE;

   tc77_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(2)) dut (
      .MCLK      (MCLK),
      .RESET     (RESET),
      .TEMP_IN   (TEMP_IN),
      .nCS       (nCS),
      .SCLK      (SCLK),
      .SIO_IN    (SIO_IN),
      .SIO_OUT   (SIO_OUT),
      .SIO_OE    (SIO_OE),
      .SHUTDOWN  (SHUTDOWN),
      .CONV_DONE (CONV_DONE)
   );

   always #5 MCLK = ~MCLK;

   int cyc  = 0;
   int base = 0;
   always @(posedge MCLK) cyc <= cyc + 1;

   typedef struct packed {
      logic [15:0] word;
      logic [15:0] oe;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [12:0] m_temp;
   logic        m_done;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge MCLK);
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      while (((cyc - base) % CONV) != p && n < 3 * CONV) begin
         @(negedge MCLK);
         n++;
      end
   endtask

   // nclk SCLK periods; the first 16 are read, the rest write wdata MSB first.
   task automatic run_frame(input string tag, input int nclk, input logic [15:0] wdata,
                            input logic chg, input logic [12:0] chg_val);
      logic [15:0] w  = '0;
      logic [15:0] oe = '0;
      exp_t        e;
      @(negedge MCLK);
      nCS = 1'b0;
      sb_q.push_back({{m_temp, m_done, 2'b00}, 16'hFFFC});
      tick(6);
      if (chg) TEMP_IN = chg_val;
      for (int i = 0; i < nclk; i++) begin
         if (i < 16) begin
            w[15-i]  = SIO_OE ? SIO_OUT : 1'b0;
            oe[15-i] = SIO_OE;
         end else begin
            SIO_IN = wdata[31-i];
         end
         SCLK = 1'b1;
         tick(HALF);
         SCLK = 1'b0;
         tick(HALF);
      end
      nCS    = 1'b1;
      SIO_IN = 1'b0;
      tick(8);
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_val({tag, "_word"}, {16'd0, w}, {16'd0, e.word});
         check_val({tag, "_oe"}, {16'd0, oe}, {16'd0, e.oe});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET   = 1'b1;
      nCS     = 1'b1;
      SCLK    = 1'b0;
      SIO_IN  = 1'b0;
      TEMP_IN = 13'h0190;
      m_temp  = 13'h0000;
      m_done  = 1'b0;
      tick(4);
      check_val("rst_oe", SIO_OE, 0);
      check_val("rst_out", SIO_OUT, 0);
      check_val("rst_shdn", SHUTDOWN, 0);
      check_val("rst_done", CONV_DONE, 0);
      RESET = 1'b0;
      base  = cyc;

      // before first conversion
      run_frame("rd_initial", 16, 16'h0, 1'b0, 13'h0);

      // +25 C
      wait_phase(150);
      check_val("done_25C", CONV_DONE, 1);
      m_temp = 13'h0190;
      m_done = 1'b1;
      run_frame("rd_25C", 16, 16'h0, 1'b0, 13'h0);

      // -40 C
      TEMP_IN = 13'h1D80;
      wait_phase(150);
      m_temp = 13'h1D80;
      run_frame("rd_m40C", 16, 16'h0, 1'b0, 13'h0);

      // conversion ends mid-frame with a new TEMP_IN
      wait_phase(330);
      run_frame("rd_midconv", 16, 16'h0, 1'b1, 13'h0190);
      m_temp = 13'h0190;
      run_frame("rd_after_conv", 16, 16'h0, 1'b0, 13'h0);

      // shutdown
      run_frame("wr_shdn", 32, 16'hFFFF, 1'b0, 13'h0);
      check_val("shdn_set", SHUTDOWN, 1);
      TEMP_IN = 13'h1D80;
      tick(3 * CONV);
      run_frame("rd_shdn", 16, 16'h0, 1'b0, 13'h0);
      check_val("shdn_hold_rd", SHUTDOWN, 1);
      check_val("shdn_done", CONV_DONE, 1);
      run_frame("wr_abort_cont", 20, 16'h0000, 1'b0, 13'h0);
      check_val("shdn_after_abort", SHUTDOWN, 1);

      // back to continuous
      run_frame("wr_cont", 32, 16'h0000, 1'b0, 13'h0);
      base = cyc;
      check_val("cont_shdn", SHUTDOWN, 0);
      check_val("cont_done_clr", CONV_DONE, 0);
      m_done = 1'b0;
      run_frame("rd_restart", 16, 16'h0, 1'b0, 13'h0);
      wait_phase(150);
      check_val("cont_done_set", CONV_DONE, 1);
      m_temp = 13'h1D80;
      m_done = 1'b1;
      run_frame("rd_restart2", 16, 16'h0, 1'b0, 13'h0);

      // aborted and unrecognised writes
      run_frame("wr_abort", 20, 16'hFFFF, 1'b0, 13'h0);
      check_val("abort_shdn", SHUTDOWN, 0);
      run_frame("wr_1234", 32, 16'h1234, 1'b0, 13'h0);
      check_val("ign_shdn", SHUTDOWN, 0);
      check_val("ign_done", CONV_DONE, 1);
      run_frame("rd_post_ignore", 16, 16'h0, 1'b0, 13'h0);

      // reset during a read
      @(negedge MCLK);
      nCS = 1'b0;
      tick(6);
      for (int i = 0; i < 7; i++) begin
         SCLK = 1'b1;
         tick(HALF);
         SCLK = 1'b0;
         tick(HALF);
      end
      check_val("oe_before_rst", SIO_OE, 1);
      @(posedge MCLK);
      #2 RESET = 1'b1;
      #1;
      check_val("midrst_oe", SIO_OE, 0);
      check_val("midrst_out", SIO_OUT, 0);
      check_val("midrst_done", CONV_DONE, 0);
      check_val("midrst_shdn", SHUTDOWN, 0);
      tick(3);
      RESET  = 1'b0;
      base   = cyc;
      m_temp = 13'h0000;
      m_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         SCLK = 1'b1;
         tick(HALF);
         check_val("rel_oe_hi", SIO_OE, 0);
         SCLK = 1'b0;
         tick(HALF);
         check_val("rel_oe_lo", SIO_OE, 0);
      end
      nCS = 1'b1;
      tick(8);
      check_val("rel_oe_idle", SIO_OE, 0);
      run_frame("rd_after_rst", 16, 16'h0, 1'b0, 13'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
